// File: rtl/hack_clk_monitor.sv
// rtl/hack_clk_monitor.sv - Hack CPU clock edge detector, half-period meter and lock monitor (optional HACK_CLK_SYNC_EN input synchronizer)
module hack_clk_monitor #(
    parameter int EXPECTED_HALF = 31,
    parameter int TOLERANCE     = 2,
    parameter int LOCK_COUNT    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hack_clk_in,
    input  logic             err_clear,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W:0] HALF_HI = (CNT_W+1)'(EXPECTED_HALF + TOLERANCE);
    localparam logic [CNT_W:0] HALF_LO = (EXPECTED_HALF > TOLERANCE) ?
                                         (CNT_W+1)'(EXPECTED_HALF - TOLERANCE) : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [GOOD_W-1:0] LOCK_N  = GOOD_W'(LOCK_COUNT);

    logic              cond;
    logic              prev;
    logic              edge_det;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    cnt_ext;
    logic              good_half;
    logic              timeout;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_nxt;
    logic [GOOD_W-1:0] good_inc;
    logic              publish;
    logic              err_set;

`ifdef HACK_CLK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], hack_clk_in};
        end
    end

    assign cond = sync_q[1];
`else
    assign cond = hack_clk_in;
`endif

    assign edge_det = cond ^ prev;
    assign cnt_ext  = {1'b0, cnt};
    assign good_inc = good + 1'b1;

    // cnt still holds the length of the half that just ended on the edge cycle
    always_comb begin
        good_half = (cnt_ext >= HALF_LO) && (cnt_ext <= HALF_HI);
        timeout   = !edge_det && (cnt_ext > HALF_HI);
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        publish   = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (edge_det) begin
                    state_nxt = S_TRACK;
                    good_nxt  = '0;
                end
            end
            S_TRACK: begin
                if (edge_det) begin
                    publish = 1'b1;
                    if (good_half) begin
                        good_nxt = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_nxt = S_LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                    good_nxt  = '0;
                end
            end
            S_LOCKED: begin
                if (edge_det) begin
                    publish = 1'b1;
                    if (!good_half) begin
                        err_set   = 1'b1;
                        state_nxt = S_TRACK;
                        good_nxt  = '0;
                    end
                end else if (timeout) begin
                    err_set   = 1'b1;
                    state_nxt = S_IDLE;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= 1'b0;
            cnt          <= '0;
            state        <= S_IDLE;
            good         <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            error        <= 1'b0;
        end else begin
            prev         <= cond;
            rise_pulse   <= edge_det & cond;
            fall_pulse   <= edge_det & ~cond;
            period_valid <= publish;
            state        <= state_nxt;
            good         <= good_nxt;
            locked       <= (state_nxt == S_LOCKED);
            if (edge_det) begin
                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (publish) begin
                half_period <= cnt;
            end
            // a fault in the same cycle as a clear request must not be lost
            if (err_set) begin
                error <= 1'b1;
            end else if (err_clear) begin
                error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hack_clk_monitor.sv
// tb/tb_hack_clk_monitor.sv - scoreboard bench for hack_clk_monitor
module tb_hack_clk_monitor;

    localparam int EXP_HALF = 31;
    localparam int TOL      = 2;
    localparam int LOCK_N   = 4;
`ifdef HACK_CLK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [7:0] half;
        logic       lck;
        logic       err;
    } meas_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       hack_clk_in = 1'b0;
    logic       err_clear = 1'b0;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] half_period;
    logic       period_valid;
    logic       locked;
    logic       error;

    hack_clk_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hack_clk_in  (hack_clk_in),
        .err_clear    (err_clear),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .half_period  (half_period),
        .period_valid (period_valid),
        .locked       (locked),
        .error        (error)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    meas_t exp_q[$];
    meas_t obs_q[$];
    int    m_state = 0;
    int    m_good = 0;
    int    m_gap = 0;
    logic  m_err = 1'b0;
    int    rise_cnt = 0;
    int    fall_cnt = 0;
    int    lock_drop_idx = 0;
    int    err_rise_idx = 0;

    task automatic tick(input int j);
        meas_t o;
        @(negedge clk);
        if (period_valid) begin
            o.half = half_period;
            o.lck  = locked;
            o.err  = error;
            obs_q.push_back(o);
        end
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
        if (lock_drop_idx == 0 && !locked) lock_drop_idx = j;
        if (err_rise_idx == 0 && error) err_rise_idx = j;
        m_gap++;
        if (m_gap == EXP_HALF + TOL + 2 && m_state != 0) begin
            if (m_state == 2) m_err = 1'b1;
            m_state = 0;
            m_good  = 0;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int j = 1; j <= n; j++) tick(j);
    endtask

    task automatic model_edge();
        meas_t e;
        logic  g;
        if (m_state == 0) begin
            m_state = 1;
            m_good  = 0;
        end else begin
            g = (m_gap >= EXP_HALF - TOL) && (m_gap <= EXP_HALF + TOL);
            if (m_state == 1) begin
                if (g) begin
                    m_good++;
                    if (m_good == LOCK_N) m_state = 2;
                end else begin
                    m_good = 0;
                end
            end else if (!g) begin
                m_err   = 1'b1;
                m_state = 1;
                m_good  = 0;
            end
            e.half = 8'((m_gap > 255) ? 255 : m_gap);
            e.lck  = (m_state == 2);
            e.err  = m_err;
            exp_q.push_back(e);
        end
    endtask

    task automatic toggle_and_wait(input int n, input int clr_at);
        model_edge();
        hack_clk_in = ~hack_clk_in;
        m_gap = 0;
        for (int j = 1; j <= n; j++) begin
            tick(j);
            err_clear = (j == clr_at);
        end
        err_clear = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        hack_clk_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_state = 0;
        m_good  = 0;
        m_err   = 1'b0;
        m_gap   = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({rise_pulse, fall_pulse, period_valid, locked, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {rise_pulse, fall_pulse, period_valid, locked, error});
        end
        checks++;
        if (half_period !== 8'd0) begin
            failures++;
            $display("FAIL reset_half: got %0d expected 0", half_period);
        end
    endtask

    task automatic test_lock();
        meas_t e, o;
        rise_cnt = 0;
        fall_cnt = 0;
        for (int k = 0; k < 6; k++) toggle_and_wait(EXP_HALF, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL lock_count: got %0d measurements expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lock_meas: got half=%0d lck=%b err=%b expected half=%0d lck=%b err=%b",
                         o.half, o.lck, o.err, e.half, e.lck, e.err);
            end
        end
        checks++;
        if (rise_cnt !== 3 || fall_cnt !== 3) begin
            failures++;
            $display("FAIL lock_pulses: got rise=%0d fall=%0d expected rise=3 fall=3", rise_cnt, fall_cnt);
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_state: got %b expected 1", locked);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_bad_locked();
        meas_t e, o;
        toggle_and_wait(20, 0);
        toggle_and_wait(EXP_HALF, 0);
        checks++;
        if (locked !== 1'b0 || error !== 1'b1) begin
            failures++;
            $display("FAIL bad_half_state: got lck=%b err=%b expected lck=0 err=1", locked, error);
        end
        for (int k = 0; k < 4; k++) toggle_and_wait(EXP_HALF, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL bad_count: got %0d measurements expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bad_meas: got half=%0d lck=%b err=%b expected half=%0d lck=%b err=%b",
                         o.half, o.lck, o.err, e.half, e.lck, e.err);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_err_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        m_err = 1'b0;
        tick(2);
        checks++;
        if (error !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL err_clear: got err=%b lck=%b expected err=0 lck=1", error, locked);
        end
    endtask

    task automatic test_timeout();
        meas_t e, o;
        lock_drop_idx = 0;
        err_rise_idx  = 0;
        toggle_and_wait(40, EXP_HALF + TOL + 1 + (LAT - 1));
        checks++;
        if (lock_drop_idx !== EXP_HALF + TOL + 2 + (LAT - 1)) begin
            failures++;
            $display("FAIL timeout_lock_drop: got cycle %0d expected %0d", lock_drop_idx, EXP_HALF + TOL + 2 + (LAT - 1));
        end
        checks++;
        if (err_rise_idx !== EXP_HALF + TOL + 2 + (LAT - 1)) begin
            failures++;
            $display("FAIL timeout_err_rise: got cycle %0d expected %0d", err_rise_idx, EXP_HALF + TOL + 2 + (LAT - 1));
        end
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clear: got err=%b expected 1", error);
        end
        wait_cycles(300);
        checks++;
        if (dut.cnt !== 8'hFF) begin
            failures++;
            $display("FAIL cnt_saturate: got %0d expected 255", dut.cnt);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL timeout_count: got %0d measurements expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout_meas: got half=%0d lck=%b err=%b expected half=%0d lck=%b err=%b",
                         o.half, o.lck, o.err, e.half, e.lck, e.err);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_lock();
        for (int k = 0; k < 6; k++) toggle_and_wait(EXP_HALF, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL relock_before_reset: got %b expected 1", locked);
        end
        wait_cycles(5);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rise_pulse, fall_pulse, period_valid, locked, error, half_period} !== 13'b0) begin
            failures++;
            $display("FAIL async_reset: got %b expected all 0",
                     {rise_pulse, fall_pulse, period_valid, locked, error, half_period});
        end
        @(negedge clk);
        hack_clk_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_state = 0;
        m_good  = 0;
        m_err   = 1'b0;
        m_gap   = 0;
        exp_q.delete();
        obs_q.delete();
        toggle_and_wait(EXP_HALF, 0);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL first_edge_after_reset: got %0d measurements expected 0", obs_q.size());
        end
    endtask

    task automatic test_latency();
        int rise_idx, rise_w, fall_idx, fall_w;
        apply_reset();
        wait_cycles(3);
        rise_idx = 0; rise_w = 0; fall_idx = 0; fall_w = 0;
        hack_clk_in = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (rise_pulse) begin
                if (rise_idx == 0) rise_idx = j;
                rise_w++;
            end
        end
        hack_clk_in = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (fall_pulse) begin
                if (fall_idx == 0) fall_idx = j;
                fall_w++;
            end
        end
        checks++;
        if (rise_idx !== LAT || rise_w !== 1) begin
            failures++;
            $display("FAIL rise_latency: got cycle=%0d width=%0d expected cycle=%0d width=1", rise_idx, rise_w, LAT);
        end
        checks++;
        if (fall_idx !== LAT || fall_w !== 1) begin
            failures++;
            $display("FAIL fall_latency: got cycle=%0d width=%0d expected cycle=%0d width=1", fall_idx, fall_w, LAT);
        end
    endtask

    initial begin
        #1 reset_n = 1'b0;
        test_reset();
        test_lock();
        test_bad_locked();
        test_err_clear();
        test_timeout();
        test_reset_mid_lock();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
